rcs_wr_arbiter: RTL and testbench



---
 rtl/rcs_wr_arbiter_pkg.sv | 44 ++++
 rtl/rcs_wr_arbiter_rr_arb2.sv | 34 +++
 rtl/rcs_wr_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_rcs_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcs_wr_arbiter_pkg.sv
// Shared types and constants for the RCS write arbiter: FSM encoding, AXI
// burst constants and the {r, c, s} command word layout.
package rcs_wr_arbiter_pkg;

    localparam int unsigned AXI_AW = 32;
    localparam int unsigned AXI_DW = 32;
    localparam int unsigned RCS_W  = 96;

    localparam int unsigned RCS_S_LSB = 0;
    localparam int unsigned RCS_C_LSB = 32;
    localparam int unsigned RCS_R_LSB = 64;

    localparam logic [7:0] AXI_LEN_3BEAT  = 8'd2;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [1:0] BEAT_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } state_e;

    typedef struct packed {
        logic [AXI_DW-1:0] r;
        logic [AXI_DW-1:0] c;
        logic [AXI_DW-1:0] s;
    } rcs_cmd_t;

    // Write-data word for beat 0/1/2 (r, c, s order on the bus)
    function automatic logic [AXI_DW-1:0] rcs_beat(input rcs_cmd_t cmd, input logic [1:0] beat);
        logic [RCS_W-1:0] word;
        word = cmd;
        case (beat)
            2'd0:    return word[RCS_R_LSB +: AXI_DW];
            2'd1:    return word[RCS_C_LSB +: AXI_DW];
            default: return word[RCS_S_LSB +: AXI_DW];
        endcase
    endfunction

endpackage

// File: rtl/rcs_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last served source
// and moves only on the update strobe.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] grant_c,
    output logic       gnt_id_c,
    output logic       any_c
);

    logic last_q;

    // Reset value 1 makes req0 the favoured source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (upd) begin
            last_q <= upd_id;
        end
    end

    always_comb begin
        any_c    = |req;
        gnt_id_c = (req == 2'b11) ? ~last_q : req[1];
        grant_c  = 2'b00;
        if (any_c) begin
            grant_c = gnt_id_c ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/rcs_wr_arbiter.sv
// Shares one AXI4 write master between two RCS command sources, issuing a
// 3-beat INCR burst per command. Optional B watchdog: RCS_ARB_TIMEOUT_EN.
module rcs_wr_arbiter
    import rcs_wr_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR_0 = 32'h28040000,
    parameter logic [31:0] BASE_ADDR_1 = 32'h28400010,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              req0_valid,
    input  logic [RCS_W-1:0]  req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [RCS_W-1:0]  req1_data,
    output logic              req1_ready,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [AXI_AW-1:0] M_AXI_AWADDR,
    output logic [7:0]        M_AXI_AWLEN,
    output logic [2:0]        M_AXI_AWSIZE,
    output logic [1:0]        M_AXI_AWBURST,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [AXI_DW-1:0] M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WLAST,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY
);

    // Reject degenerate watchdog limits at elaboration
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_e            state_q, state_d;
    rcs_cmd_t          cmd_q, cmd_d;
    logic              id_q, id_d;
    logic [1:0]        beat_q, beat_d;
    logic              awvalid_q, awvalid_d;
    logic [AXI_AW-1:0] awaddr_q, awaddr_d;
    logic              wvalid_q, wvalid_d;
    logic [AXI_DW-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wlast_q, wlast_d;
    logic              bready_q, bready_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              en_q;

    logic [1:0]        grant_c;
    logic              gnt_id_c;
    logic              gnt_any_c;
    logic              rr_upd_c;

`ifdef RCS_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (aresetn),
        .req      ({req1_valid, req0_valid}),
        .upd      (rr_upd_c),
        .upd_id   (id_q),
        .grant_c  (grant_c),
        .gnt_id_c (gnt_id_c),
        .any_c    (gnt_any_c)
    );

    // Ready is the accept strobe itself: only in IDLE, only for the winner
    assign req0_ready = en_q && (state_q == ST_IDLE) && grant_c[0];
    assign req1_ready = en_q && (state_q == ST_IDLE) && grant_c[1];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            id_q      <= 1'b0;
            beat_q    <= 2'd0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= 4'h0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            en_q      <= 1'b0;
`ifdef RCS_ARB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            id_q      <= id_d;
            beat_q    <= beat_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            en_q      <= 1'b1;
`ifdef RCS_ARB_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        id_d      = id_q;
        beat_d    = beat_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rr_upd_c  = 1'b0;
`ifdef RCS_ARB_TIMEOUT_EN
        tmo_d     = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (en_q && gnt_any_c) begin
                    cmd_d     = rcs_cmd_t'(gnt_id_c ? req1_data : req0_data);
                    id_d      = gnt_id_c;
                    awvalid_d = 1'b1;
                    awaddr_d  = gnt_id_c ? BASE_ADDR_1 : BASE_ADDR_0;
                    state_d   = ST_AW;
                end
            end
            ST_AW: begin
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wdata_d   = rcs_beat(cmd_q, 2'd0);
                    wlast_d   = 1'b0;
                    beat_d    = 2'd0;
                    state_d   = ST_W;
                end
            end
            ST_W: begin
                if (wvalid_q && M_AXI_WREADY) begin
                    if (beat_q == BEAT_LAST) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        wdata_d = rcs_beat(cmd_q, beat_q + 2'd1);
                        wlast_d = ((beat_q + 2'd1) == BEAT_LAST);
                    end
                end
            end
            ST_B: begin
                if (bready_q && M_AXI_BVALID) begin
                    bready_d     = 1'b0;
                    done_d[id_q] = 1'b1;
                    err_d[id_q]  = (M_AXI_BRESP != AXI_RESP_OKAY);
                    rr_upd_c     = 1'b1;
                    state_d      = ST_IDLE;
                end
`ifdef RCS_ARB_TIMEOUT_EN
                // Watchdog: abandon the response after TIMEOUT_CYC cycles in B
                else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    bready_d     = 1'b0;
                    done_d[id_q] = 1'b1;
                    err_d[id_q]  = 1'b1;
                    rr_upd_c     = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wstrb_d = wvalid_d ? 4'hF : 4'h0;
    end

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = AXI_LEN_3BEAT;
    assign M_AXI_AWSIZE  = AXI_SIZE_4B;
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign done0         = done_q[0];
    assign done1         = done_q[1];
    assign err0          = err_q[0];
    assign err1          = err_q[1];

endmodule

// File: tb/tb_rcs_wr_arbiter.sv
// Scoreboard bench for rcs_wr_arbiter: expected AW/W/done traffic is queued
// when a command is posted and compared as the DUT emits it.
module tb_rcs_wr_arbiter;

    localparam logic [31:0] A0 = 32'h28040000;
    localparam logic [31:0] A1 = 32'h28400010;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [95:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        done0, done1, err0, err1;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, wvalid, wlast, bready;
    logic        awready = 1'b1, wready = 1'b1, bvalid = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = 2'b00;

    always #5 clk = ~clk;

    rcs_wr_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .aresetn(aresetn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    logic [31:0] exp_aw[$];
    logic [32:0] exp_w[$];
    logic [1:0]  exp_done[$];
    logic        last_srv = 1'b1;
    int posted0 = 0, posted1 = 0, acc0_n = 0, acc1_n = 0;
    int w_hs = 0, aw_stall = 0;
    int acc_cyc = 0, done_cyc = 0, b_enter_cyc = 0;
    logic prev_bready = 1'b0;
    bit acc0 = 0, acc1 = 0;
    int aw_wait = 0;
    bit w_toggle = 0, b_en = 1;
    logic [1:0] slave_bresp = 2'b00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Slave model: programmable AW stall, toggling WREADY, immediate B
    always @(posedge clk) begin
        #1;
        if (awvalid && aw_wait > 0) begin
            awready = 1'b0;
            aw_wait--;
        end else begin
            awready = 1'b1;
        end
        wready = w_toggle ? ~wready : 1'b1;
        bvalid = b_en && bready;
        bresp  = bvalid ? slave_bresp : 2'b00;
    end

    // Sources drop valid the cycle after their accept
    always @(posedge clk) begin
        #1;
        if (acc0) begin req0_valid = 1'b0; acc0 = 0; end
        if (acc1) begin req1_valid = 1'b0; acc1 = 0; end
    end

    // Monitor, sampling mid-cycle
    always @(negedge clk) begin
        if (aresetn) begin
            if (req0_valid && req0_ready) begin acc0 = 1; acc0_n++; acc_cyc = cyc; end
            if (req1_valid && req1_ready) begin acc1 = 1; acc1_n++; acc_cyc = cyc; end
            if (bready && !prev_bready) b_enter_cyc = cyc;
            prev_bready = bready;
            if (awvalid) begin
                check("aw_pending", 64'(exp_aw.size() > 0), 64'd1);
                if (exp_aw.size() > 0) begin
                    check("awaddr", awaddr, exp_aw[0]);
                    if (awready) begin
                        void'(exp_aw.pop_front());
                        check("awlen", awlen, 8'd2);
                        check("awsize", awsize, 3'b010);
                        check("awburst", awburst, 2'b01);
                    end else begin
                        aw_stall++;
                    end
                end
            end
            if (wvalid) begin
                check("w_pending", 64'(exp_w.size() > 0), 64'd1);
                if (exp_w.size() > 0) begin
                    check("wdata", wdata, exp_w[0][31:0]);
                    check("wlast", wlast, exp_w[0][32]);
                    check("wstrb", wstrb, 4'hF);
                    if (wready) begin
                        void'(exp_w.pop_front());
                        w_hs++;
                    end
                end
            end else begin
                check("wstrb_idle", wstrb, 4'h0);
            end
            if (done0 || done1 || err0 || err1) begin
                check("done_pending", 64'(exp_done.size() > 0), 64'd1);
                if (exp_done.size() > 0) begin
                    logic [1:0] d;
                    logic [1:0] onehot;
                    d = exp_done.pop_front();
                    onehot = d[1] ? 2'b10 : 2'b01;
                    check("done", {done1, done0}, onehot);
                    check("err", {err1, err0}, d[0] ? onehot : 2'b00);
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic expect_cmd(input logic id, input logic [95:0] d, input logic err);
        exp_aw.push_back(id ? A1 : A0);
        exp_w.push_back({1'b0, d[95:64]});
        exp_w.push_back({1'b0, d[63:32]});
        exp_w.push_back({1'b1, d[31:0]});
        exp_done.push_back({id, err});
        last_srv = id;
    endtask

    task automatic post(input logic id, input logic [95:0] d, input logic err);
        expect_cmd(id, d, err);
        if (id) begin req1_data = d; req1_valid = 1'b1; posted1++; end
        else    begin req0_data = d; req0_valid = 1'b1; posted0++; end
    endtask

    // Both sources valid together; the model predicts the service order
    task automatic post_pair(input logic [95:0] d0, input logic [95:0] d1);
        if (last_srv) begin
            expect_cmd(1'b0, d0, 1'b0);
            expect_cmd(1'b1, d1, 1'b0);
        end else begin
            expect_cmd(1'b1, d1, 1'b0);
            expect_cmd(1'b0, d0, 1'b0);
        end
        req0_data = d0; req1_data = d1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        posted0++; posted1++;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_done.size() == 0) break;
            @(posedge clk);
        end
        check(tag, 64'(exp_done.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        bit seen;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_wstrb", wstrb, 4'h0);
        check("rst_done_err", {done1, done0, err1, err0}, 4'h0);
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);
        @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Simultaneous pair from reset: req0 wins
        check("pair1_first", last_srv, 1'b1);
        post_pair({32'hA0, 32'hA1, 32'hA2}, {32'hB0, 32'hB1, 32'hB2});
        drain("drain_pair1", 40);

        // Single req0, zero-wait latency
        post(1'b0, {32'h11, 32'h22, 32'h33}, 1'b0);
        drain("drain_single", 30);
        check("latency", 64'(done_cyc - acc_cyc), 64'd6);

        // Second pair after req0 was served: req1 wins
        post_pair({32'hC0, 32'hC1, 32'hC2}, {32'hD0, 32'hD1, 32'hD2});
        drain("drain_pair2", 40);

        // Backpressure on AW and W
        w0 = w_hs;
        aw_stall = 0;
        aw_wait = 5;
        w_toggle = 1;
        post(1'b1, {32'hE0, 32'hE1, 32'hE2}, 1'b0);
        drain("drain_bp", 60);
        w_toggle = 0;
        check("bp_w_beats", 64'(w_hs - w0), 64'd3);
        check("bp_aw_stall", 64'(aw_stall), 64'd5);

        // Error response on req1, then a normal command
        slave_bresp = 2'b10;
        post(1'b1, {32'h5A, 32'h5B, 32'h5C}, 1'b1);
        drain("drain_err", 30);
        slave_bresp = 2'b00;
        post(1'b0, {32'h61, 32'h62, 32'h63}, 1'b0);
        drain("drain_after_err", 30);

        // Reset while beat c is on the bus
        post(1'b0, {32'h71, 32'h72, 32'h73}, 1'b0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wvalid && wdata == 32'h72) begin seen = 1; break; end
        end
        check("reach_beat_c", seen, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_awvalid", awvalid, 1'b0);
        check("arst_wvalid", wvalid, 1'b0);
        check("arst_wdata", wdata, 32'h0);
        check("arst_wlast", wlast, 1'b0);
        check("arst_wstrb", wstrb, 4'h0);
        check("arst_bready", bready, 1'b0);
        check("arst_awaddr", awaddr, 32'h0);
        check("arst_done_err", {done1, done0, err1, err0}, 4'h0);
        exp_aw.delete(); exp_w.delete(); exp_done.delete();
        last_srv = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        w0 = w_hs;
        post(1'b0, {32'h81, 32'h82, 32'h83}, 1'b0);
        drain("drain_after_rst", 30);
        check("rst_fresh_beats", 64'(w_hs - w0), 64'd3);

`ifdef RCS_ARB_TIMEOUT_EN
        // No B response: watchdog completes with error after 16 cycles in B
        b_en = 0;
        post(1'b1, {32'h91, 32'h92, 32'h93}, 1'b1);
        drain("drain_timeout", 60);
        check("timeout_cycles", 64'(done_cyc - b_enter_cyc), 64'd16);
        check("timeout_bready", bready, 1'b0);
        b_en = 1;
        post(1'b0, {32'hA1, 32'hA2, 32'hA3}, 1'b0);
        drain("drain_after_timeout", 30);
`endif

        check("accepts0", 64'(acc0_n), 64'(posted0));
        check("accepts1", 64'(acc1_n), 64'(posted1));
        check("aw_q_empty", 64'(exp_aw.size()), 64'd0);
        check("w_q_empty", 64'(exp_w.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
